qbert_only_cpu_debug_scan_master: RTL and testbench
===================================================

// Module: qbert_only_cpu_debug_scan_master
// PURPOSE
//  Host-side initiator for the Nios II debug slave virtual-JTAG port, in a single clk domain.
//  Converts a parallel {IR, DR} command into one full virtual-JTAG transaction:
//  UIR, CDR, DR_WIDTH SDR bit-slots, UDR, then RTI.
//  Captures serial tdo into a parallel response word.
//  Used to drive the debug slave in on-chip test harnesses and bench loopback, in place of the hard JTAG hub.
// PARAMETERS
//  DR_WIDTH  38  data-register length in bits (matches debug slave jdo/sr width)
//  IR_WIDTH  2   virtual IR width
//  TCK_DIV   4   clk cycles per tck bit-slot; must be even and >= 2
// PORTS
//  clk            in   1         system clock; all logic rising-edge
//  reset          in   1         asynchronous, active-high reset
//  cmd_valid      in   1         command request
//  cmd_ready      out  1         high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_ir         in   IR_WIDTH  IR code (package constants OCIMEM/TRACECTRL/BREAK/TRACEMEM)
//  cmd_dr         in   DR_WIDTH  DR word to shift in, LSB first
//  rsp_valid      out  1         response available; held until rsp_ready
//  rsp_ready      in   1         response consumed
//  rsp_data       out  DR_WIDTH  captured tdo word, bit i = i-th sampled tdo bit
//  tck            out  1         divided scan clock: low in 1st half of each slot, high in 2nd half
//  tdi            out  1         serial data to slave
//  tdo            in   1         serial data from slave
//  ir_in          out  IR_WIDTH  IR presented to slave; registered at accept, held until next UIR
//  vs_uir         out  1         high for the whole UIR slot
//  vs_cdr         out  1         high for the whole CDR slot
//  vs_sdr         out  1         high for all SDR slots
//  vs_udr         out  1         high for the whole UDR slot
//  jtag_state_rti out  1         high in RTI slot and while IDLE
// BEHAVIOUR
//  Reset values: cmd_ready=0 during reset, 1 on the first cycle after; rsp_valid=0; rsp_data=0;
//   tck=0; tdi=0; ir_in=0; all vs_*=0; jtag_state_rti=1.
//  FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
//   UIR, CDR, UDR and RTI each last exactly one slot (TCK_DIV clks). SDR lasts DR_WIDTH slots.
//   RESP waits for rsp_ready (cmd_ready=0 throughout).
//  Slot counter runs 0..TCK_DIV-1; tck=1 when count >= TCK_DIV/2.
//  SDR slot k (k = 0..DR_WIDTH-1):
//   - tdi = shift[0] for the whole slot.
//   - tdo is sampled on the clk edge where tck rises.
//   - At slot end, shift = {sampled_tdo, shift[DR_WIDTH-1:1]}.
//  tdi = 0 outside SDR.
//  Latency: accept on edge t; rsp_valid rises on edge t + (DR_WIDTH+4)*TCK_DIV (168 clks for the defaults).
//   rsp_data is loaded on that same edge.
//  rsp_valid and rsp_ready both high -> IDLE next cycle, so cmd_ready=1 one cycle after the handshake.
//   rsp_data holds until the next response.
//  cmd_valid while busy: ignored; the command stays pending until IDLE.
//  reset asserted mid-transaction: all state aborts to reset values immediately.
//   No UDR is issued and no response is produced.
//  Width rule: no arithmetic on data; the slot counter is $clog2(TCK_DIV) bits.
//   The bit counter is $clog2(DR_WIDTH) bits and wraps only through the FSM exit.
// CONFIGURATION
//  DEBUG_SCAN_SKIP_IR_EN defined:
//   - Track last_ir (reset 0) plus a valid flag (reset 0).
//   - If the flag is set and cmd_ir == last_ir, go IDLE -> CDR directly with no UIR slot.
//   - Latency is then (DR_WIDTH+3)*TCK_DIV.
//  DEBUG_SCAN_SKIP_IR_EN undefined: every transaction issues UIR; no last_ir logic is present.
// STRUCTURE
//  Package qbert_only_cpu_debug_scan_pkg:
//   - FSM state enum.
//   - IR code constants: OCIMEM=2'b00, TRACECTRL=2'b01, BREAK=2'b10, TRACEMEM=2'b11.
//   - Default DR_WIDTH and IR_WIDTH localparams.
//  Sub-module qbert_only_cpu_debug_scan_tckgen:
//   - Slot counter plus tck generation.
//   - Outputs slot_end, tck_rise and tck.
//   - Enabled only when the FSM is outside IDLE/RESP.
// TESTING
//  1. Loopback (tdo=tdi), cmd_ir=2'b10, cmd_dr=38'h2A_DEAD_BEEF
//     -> rsp_data=38'h2A_DEAD_BEEF; rsp_valid 168 clks after accept.
//     -> vs_uir, vs_cdr and vs_udr each high for 4 clks; vs_sdr high for 152 clks.
//  2. tdo tied 1, any cmd -> rsp_data = all ones (38'h3F_FFFF_FFFF); tied 0 -> all zeros.
//  3. rsp_ready held low for 10 clks after rsp_valid
//     -> rsp_valid and rsp_data stable; cmd_ready=0; a second cmd_valid is not accepted until after the handshake.
//  4. reset pulsed at SDR slot 20 -> next clk all outputs at reset values.
//     -> A new cmd after release completes normally, with a full UIR issued.
//  5. DEBUG_SCAN_SKIP_IR_EN defined, two cmds with ir=2'b01
//     -> first takes 168 clks with a UIR; second takes 164 clks with no vs_uir pulse.
//     -> A third cmd with ir=2'b11 issues a UIR again.
//  6. Serial order: cmd_dr=38'h1, loopback -> tdi=1 only during SDR slot 0; rsp_data=38'h1.

Source files
------------

// File: rtl/qbert_only_cpu_debug_scan_pkg.sv
// Shared types and constants for the debug-slave virtual-JTAG scan master.
// FSM state encoding, IR codes and default register widths.
package qbert_only_cpu_debug_scan_pkg;

  localparam int DR_W = 38;
  localparam int IR_W = 2;

  localparam logic [1:0] OCIMEM    = 2'b00;
  localparam logic [1:0] TRACECTRL = 2'b01;
  localparam logic [1:0] BREAK     = 2'b10;
  localparam logic [1:0] TRACEMEM  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

endpackage

// File: rtl/qbert_only_cpu_debug_scan_tckgen.sv
// Bit-slot counter and divided scan clock.
// tck is low in the first half of a slot and high in the second half.
module qbert_only_cpu_debug_scan_tckgen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic slot_end
);

  localparam int CW = $clog2(TCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV / 2);
  localparam logic [CW-1:0] RISE = CW'(TCK_DIV / 2 - 1);

  logic [CW-1:0] cnt;

  // Slot counter: parked at zero while disabled, wraps each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tck      = en & (cnt >= HALF);
  assign tck_rise = en & (cnt == RISE);
  assign slot_end = en & (cnt == LAST);

endmodule

// File: rtl/qbert_only_cpu_debug_scan_master.sv
// Virtual-JTAG scan master: one {IR, DR} command becomes UIR, CDR, SDR, UDR, RTI.
// Optional DEBUG_SCAN_SKIP_IR_EN skips UIR when the IR matches the last one loaded.
module qbert_only_cpu_debug_scan_master
  import qbert_only_cpu_debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DR_W,
  parameter int IR_WIDTH = IR_W,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int BW = $clog2(DR_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  state_t              state;
  logic [DR_WIDTH-1:0] shift;
  logic [BW-1:0]       bit_cnt;
  logic                tdo_q;
  logic                tck_en;
  logic                tck_rise;
  logic                slot_end;

`ifdef DEBUG_SCAN_SKIP_IR_EN
  logic [IR_WIDTH-1:0] last_ir;
  logic                last_ok;
`endif

  assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

  qbert_only_cpu_debug_scan_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .slot_end (slot_end)
  );

  // Transaction sequencer, serial shifter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      tdo_q    <= 1'b0;
      ir_in    <= '0;
      rsp_data <= '0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
      last_ir  <= '0;
      last_ok  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            shift <= cmd_dr;
`ifdef DEBUG_SCAN_SKIP_IR_EN
            if (last_ok && (cmd_ir == last_ir)) begin
              state <= ST_CDR;
            end else begin
              state   <= ST_UIR;
              ir_in   <= cmd_ir;
              last_ir <= cmd_ir;
              last_ok <= 1'b1;
            end
`else
            state <= ST_UIR;
            ir_in <= cmd_ir;
`endif
          end
        end
        ST_UIR: begin
          if (slot_end) state <= ST_CDR;
        end
        ST_CDR: begin
          if (slot_end) state <= ST_SDR;
        end
        ST_SDR: begin
          if (tck_rise) tdo_q <= tdo;
          if (slot_end) begin
            shift <= {tdo_q, shift[DR_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= ST_UDR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_UDR: begin
          if (slot_end) state <= ST_RTI;
        end
        ST_RTI: begin
          if (slot_end) begin
            state    <= ST_RESP;
            rsp_data <= shift;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state == ST_IDLE) & ~reset;
  assign rsp_valid      = (state == ST_RESP);
  assign vs_uir         = (state == ST_UIR);
  assign vs_cdr         = (state == ST_CDR);
  assign vs_sdr         = (state == ST_SDR);
  assign vs_udr         = (state == ST_UDR);
  assign jtag_state_rti = (state == ST_IDLE) | (state == ST_RTI);
  assign tdi            = (state == ST_SDR) & shift[0];

endmodule

// File: tb/tb_qbert_only_cpu_debug_scan_master.sv
// Directed bench for the virtual-JTAG scan master.
// Loopback, tied tdo, response stall, mid-scan reset, IR skip, bit order.
module tb_qbert_only_cpu_debug_scan_master;

  localparam int W = 38;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_ir = '0;
  logic [W-1:0] cmd_dr = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         tck;
  logic         tdi;
  logic         tdo;
  logic [1:0]   ir_in;
  logic         vs_uir;
  logic         vs_cdr;
  logic         vs_sdr;
  logic         vs_udr;
  logic         jtag_state_rti;
  logic [1:0]   tdo_mode = 2'd0;

  qbert_only_cpu_debug_scan_master dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_dr         (cmd_dr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .tck            (tck),
    .tdi            (tdi),
    .tdo            (tdo),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .jtag_state_rti (jtag_state_rti)
  );

  always #5 clk = ~clk;

  assign tdo = (tdo_mode == 2'd0) ? tdi : (tdo_mode == 2'd1);

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  int c_uir, c_cdr, c_sdr, c_udr, c_tdi, first_tdi;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (vs_uir) c_uir++;
    if (vs_cdr) c_cdr++;
    if (vs_sdr) c_sdr++;
    if (vs_udr) c_udr++;
    if (tdi) begin
      if (c_tdi == 0) first_tdi = lat;
      c_tdi++;
    end
  endtask

  task automatic issue(input logic [1:0] ir, input logic [W-1:0] dr);
    int n;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0;
    c_tdi = 0; first_tdi = -1;
    sample();
  endtask

  task automatic wait_rsp();
    while (!rsp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      sample();
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("ready_after_hs", cmd_ready, 1);
    check("valid_after_hs", rsp_valid, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_outs"},
          {cmd_ready, rsp_valid, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti},
          {1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    check({tag, "_data"}, rsp_data, 0);
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_post_rst", cmd_ready, 1);

    tdo_mode = 2'd0;
    issue(2'b10, 38'h2A_DEAD_BEEF);
    check("t1_ir_in", ir_in, 2'b10);
    wait_rsp();
    check("t1_lat", lat, 168);
    check("t1_data", rsp_data, 38'h2A_DEAD_BEEF);
    check("t1_uir", c_uir, 4);
    check("t1_cdr", c_cdr, 4);
    check("t1_sdr", c_sdr, 152);
    check("t1_udr", c_udr, 4);
    handshake();
    check("t1_data_hold", rsp_data, 38'h2A_DEAD_BEEF);

    tdo_mode = 2'd1;
    issue(2'b00, '0);
    wait_rsp();
    check("t2_ones", rsp_data, ones);
    handshake();
    tdo_mode = 2'd2;
    issue(2'b11, ones);
    wait_rsp();
    check("t2_zeros", rsp_data, 0);
    handshake();

    tdo_mode = 2'd0;
    issue(2'b01, 38'h15_5555_5555);
    wait_rsp();
    check("t3_data", rsp_data, 38'h15_5555_5555);
    cmd_ir = 2'b10;
    cmd_dr = 38'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t3_hold", {rsp_valid, cmd_ready, rsp_data},
            {1'b1, 1'b0, 38'h15_5555_5555});
    end
    handshake();
    issue(2'b10, 38'h3);
    wait_rsp();
    check("t3_lat2", lat, 168);
    check("t3_data2", rsp_data, 38'h3);
    handshake();

    issue(2'b01, 38'h0F_0F0F_0F0F);
    repeat (88) begin
      @(posedge clk);
      #1;
    end
    check("t4_in_sdr", vs_sdr, 1);
    reset = 1'b1;
    #1;
    check_reset("t4_async");
    @(posedge clk);
    #1;
    check_reset("t4_clk");
    reset = 1'b0;
    #1;
    check("t4_ready", cmd_ready, 1);
    issue(2'b01, 38'h00_1234_5678);
    wait_rsp();
    check("t4_lat", lat, 168);
    check("t4_uir", c_uir, 4);
    check("t4_data", rsp_data, 38'h00_1234_5678);
    handshake();

    issue(2'b00, 38'h1);
    wait_rsp();
    check("t6_data", rsp_data, 38'h1);
    check("t6_tdi_cnt", c_tdi, 4);
    check("t6_tdi_at", first_tdi, 8);
    handshake();

    issue(2'b01, 38'h0A_5A5A_5A5A);
    wait_rsp();
    check("t5_lat1", lat, 168);
    check("t5_uir1", c_uir, 4);
    check("t5_data1", rsp_data, 38'h0A_5A5A_5A5A);
    handshake();
    issue(2'b01, 38'h31_2345_6789);
    wait_rsp();
`ifdef DEBUG_SCAN_SKIP_IR_EN
    check("t5_lat2", lat, 164);
    check("t5_uir2", c_uir, 0);
`else
    check("t5_lat2", lat, 168);
    check("t5_uir2", c_uir, 4);
`endif
    check("t5_cdr2", c_cdr, 4);
    check("t5_data2", rsp_data, 38'h31_2345_6789);
    handshake();
    issue(2'b11, 38'h00_0000_FFFF);
    wait_rsp();
    check("t5_lat3", lat, 168);
    check("t5_uir3", c_uir, 4);
    check("t5_ir3", ir_in, 2'b11);
    check("t5_data3", rsp_data, 38'h00_0000_FFFF);
    handshake();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
